// File: rtl/full_mat_pkg.sv
// Shared definitions for full_mat and its parameter loader: frame length, DH
// parameter indexing, loader address map and the fixed-point word types.
package full_mat_pkg;

  localparam int FRAME_MAX = 90;
  localparam int DATA_W    = 27;
  localparam int NJOINT    = 6;
  localparam int NPARAM    = 4;

  localparam int THETA      = 0;
  localparam int L_OFFSET   = 1;
  localparam int L_DISTANCE = 2;
  localparam int ALPHA      = 3;

  localparam logic [5:0] NWORDS           = 6'(NJOINT * NPARAM);
  localparam logic [5:0] ADDR_CTRL        = 6'd24;
  localparam logic [5:0] ADDR_STATUS      = 6'd25;
  localparam logic [5:0] ADDR_ACTIVE_BASE = 6'd32;
  localparam logic [5:0] ADDR_AUTOCOMMIT  = 6'((NJOINT - 1) * NPARAM + ALPHA);

  typedef logic [DATA_W-1:0] dh_word_t;
  typedef dh_word_t [NJOINT-1:0][NPARAM-1:0] dh_set_t;

  function automatic logic [31:0] sext_word(input dh_word_t w);
    return {{(32 - DATA_W){w[DATA_W-1]}}, w};
  endfunction

endpackage

// File: rtl/dh_param_loader_frame_seq.sv
// Frame sequencer: free-running frame count lock-stepped to full_mat, with the
// registered end-of-frame pulse and an 8-bit count of completed frames.
module frame_seq #(
  parameter int FRAME_MAX = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       wrap,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int CW = $clog2(FRAME_MAX);

  logic [CW-1:0] count;
  logic          last;

  always_comb begin
    last = (count == CW'(FRAME_MAX - 1));
    wrap = en & last;
  end

  // frame_done is registered from the count it is about to take, so it is
  // high exactly while count sits at FRAME_MAX-1 and freezes along with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (en) begin
      count      <= last ? '0 : count + 1'b1;
      frame_done <= (count == CW'(FRAME_MAX - 2));
      if (last) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dh_param_loader.sv
// DH parameter loader: host-writable shadow bank copied into the active bank
// only at a frame boundary. Define DH_LOADER_AUTOCOMMIT_EN to make a write to
// joint 5 ALPHA (address 23) also request a commit.
module dh_param_loader
  import full_mat_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output dh_set_t     dh_param,
  output logic        commit_pending,
  output logic        frame_done
);

  dh_set_t     shadow;
  dh_set_t     active;
  logic        wr_en;
  logic        rd_en;
  logic        wrap;
  logic        swap;
  logic        ctrl_req;
  logic        auto_req;
  logic        commit_req;
  logic [7:0]  frame_cnt;
  logic [31:0] rd_word;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:DATA_W];

  frame_seq #(.FRAME_MAX(FRAME_MAX)) u_frame_seq (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wrap       (wrap),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

`ifdef DH_LOADER_AUTOCOMMIT_EN
  assign auto_req = wr_en && (address == ADDR_AUTOCOMMIT);
`else
  assign auto_req = 1'b0;
`endif

  always_comb begin
    wr_en      = chipselect & write;
    rd_en      = chipselect & read;
    ctrl_req   = wr_en && (address == ADDR_CTRL) && writedata[0];
    commit_req = ctrl_req | auto_req;
    swap       = wrap & commit_pending;
  end

  // NOTE: both banks are plain flops with reset, not a RAM: full_mat must see
  // a defined all-zero set straight out of reset.
  // NOTE: non-blocking updates make the swap copy the pre-edge shadow even
  // when the host writes the shadow on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow         <= '0;
      active         <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (wr_en && (address < NWORDS))
        shadow[address[4:2]][address[1:0]] <= writedata[DATA_W-1:0];
      if (swap)
        active <= shadow;
      // A request on the swap edge wins, so the next frame swaps again.
      if (commit_req)
        commit_pending <= 1'b1;
      else if (swap)
        commit_pending <= 1'b0;
    end
  end

  // NOTE: rd_word gets a default first so no decode path infers a latch.
  always_comb begin
    rd_word = '0;
    if (address < NWORDS)
      rd_word = sext_word(shadow[address[4:2]][address[1:0]]);
    else if (address == ADDR_STATUS)
      rd_word = {16'h0000, frame_cnt, 7'h00, commit_pending};
    else if ((address >= ADDR_ACTIVE_BASE) && (address < ADDR_ACTIVE_BASE + NWORDS))
      rd_word = sext_word(active[address[4:2]][address[1:0]]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      readdata <= '0;
    else if (rd_en)
      readdata <= rd_word;
  end

  assign dh_param = active;

endmodule

// File: tb/tb_dh_param_loader.sv
// Self-checking bench for dh_param_loader: directed scenarios plus a randomized
// bus/enable run compared against an array-based behavioural model.
module tb_dh_param_loader;

  localparam int FRAME = 90;
  localparam int NW    = 24;

  typedef logic [5:0][3:0][26:0] bank_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  bank_t       dh_param;
  logic        commit_pending;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dh_param_loader dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .chipselect     (chipselect),
    .write          (write),
    .read           (read),
    .address        (address),
    .writedata      (writedata),
    .readdata       (readdata),
    .dh_param       (dh_param),
    .commit_pending (commit_pending),
    .frame_done     (frame_done)
  );

  // ---------------- behavioural reference model ----------------
  logic [26:0] m_shadow [NW];
  logic [26:0] m_active [NW];
  int          m_count;
  int          m_frames;
  logic        m_pending;
  logic [31:0] m_readdata;
  logic        m_req;
  logic        m_swap;

`ifdef DH_LOADER_AUTOCOMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  function automatic logic [31:0] sx(input logic [26:0] v);
    return {{5{v[26]}}, v};
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    if (a < 6'd24) return sx(m_shadow[a]);
    if (a == 6'd25) return {16'h0, 8'(m_frames), 7'h0, m_pending};
    if (a >= 6'd32 && a < 6'd56) return sx(m_active[a - 6'd32]);
    return 32'h0;
  endfunction

  function automatic bank_t model_active();
    bank_t r;
    for (int j = 0; j < 6; j++)
      for (int p = 0; p < 4; p++)
        r[j][p] = m_active[j*4 + p];
    return r;
  endfunction

  assign m_req  = chipselect && write &&
                  ((address == 6'd24 && writedata[0]) || (AUTO && address == 6'd23));
  assign m_swap = en && (m_count == FRAME - 1) && m_pending;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        m_shadow[i] <= '0;
        m_active[i] <= '0;
      end
      m_count    <= 0;
      m_frames   <= 0;
      m_pending  <= 1'b0;
      m_readdata <= '0;
    end else begin
      if (chipselect && read) m_readdata <= model_read(address);
      if (m_swap) m_active <= m_shadow;
      if (m_req) m_pending <= 1'b1;
      else if (m_swap) m_pending <= 1'b0;
      if (chipselect && write && address < 6'd24) m_shadow[address] <= writedata[26:0];
      if (en) begin
        if (m_count == FRAME - 1) begin
          m_count  <= 0;
          m_frames <= m_frames + 1;
        end else begin
          m_count <= m_count + 1;
        end
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    step();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_count(input int n);
    int k = 0;
    while (m_count != n && k < 400) begin
      step();
      k++;
    end
    if (m_count != n) begin
      n_checks++; n_errors++;
      $display("FAIL wait_count: count %0d, required %0d", m_count, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    int bad;
    rst = 1'b0; en = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0;
    #1 rst = 1'b1;
    #2;
    n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("FAIL reset_readdata: got %h, want 0", readdata); end
    n_checks++; if (dh_param !== '0) begin n_errors++; $display("FAIL reset_dh_param: got %h, want 0", dh_param); end
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL reset_pending: got %b, want 0", commit_pending); end
    n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b, want 0", frame_done); end
    @(negedge clk) rst = 1'b0;
    step();
    bad = 0;
    for (int a = 0; a < 56; a++) begin
      if (a >= 24 && a < 32) continue;
      bus_read(6'(a), d);
      n_checks++;
      if (d !== 32'h0) begin n_errors++; $display("FAIL reset_read[%0d]: got %h, want 0", a, d); end
    end
  endtask

  task automatic test_first_frame();
    logic [31:0] d;
    int pulses = 0;
    int k = 0;
    int bad = 0;
    bus_read(6'd25, d);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL status_before: got %h, want 00000000", d); end
    en = 1'b1;
    while (m_frames == 0 && k < 200) begin
      step();
      k++;
      if (frame_done !== (m_count == FRAME - 1)) bad++;
      if (frame_done === 1'b1) pulses++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL frame_done_timing: %0d bad cycles, want 0", bad); end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL frame_done_pulses: got %0d, want 1", pulses); end
    bus_read(6'd25, d);
    n_checks++; if (d !== 32'h0000_0100) begin n_errors++; $display("FAIL status_after: got %h, want 00000100", d); end
  endtask

  task automatic test_shadow_rw();
    logic [31:0] d;
    logic [31:0] exp;
    bus_write(6'd5, 32'h07FF_FFFF);
    bus_read(6'd5, d);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sext_neg: got %h, want ffffffff", d); end
    bus_write(6'd5, 32'h0000_1234);
    bus_read(6'd5, d);
    n_checks++; if (d !== 32'h0000_1234) begin n_errors++; $display("FAIL sext_pos: got %h, want 00001234", d); end
    n_checks++; if (dh_param[1][1] !== 27'h0) begin n_errors++; $display("FAIL active_untouched: got %h, want 0", dh_param[1][1]); end
    bus_write(6'd6, 32'hF800_0001);
    bus_read(6'd6, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_errors++; $display("FAIL upper_discard: got %h, want 00000001", d); end
    bus_write(6'd37, 32'h0000_0ABC);
    bus_write(6'd25, 32'h0000_FFFF);
    bus_read(6'd37, d);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL ro_active_write: got %h, want 0", d); end
    exp = {16'h0, 8'(m_frames), 8'h00};
    bus_read(6'd25, d);
    n_checks++; if (d !== exp) begin n_errors++; $display("FAIL ro_status_write: got %h, want %h", d, exp); end
    bus_read(6'd60, d);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL unmapped_read: got %h, want 0", d); end
    bus_read(6'd5, d);
    repeat (3) step();
    n_checks++; if (readdata !== 32'h0000_1234) begin n_errors++; $display("FAIL readdata_hold: got %h, want 00001234", readdata); end
  endtask

  logic [26:0] vals [NW];

  task automatic test_commit();
    logic [31:0] d;
    int bad = 0;
    for (int k = 0; k < NW; k++) begin
      vals[k] = 27'($urandom);
      bus_write(6'(k), {5'($urandom), vals[k]});
    end
    wait_count(40);
    bus_write(6'd24, 32'h1);
    while (m_count != FRAME - 1) begin
      if (commit_pending !== 1'b1) bad++;
      step();
    end
    n_checks++; if (bad != 0 || commit_pending !== 1'b1) begin n_errors++; $display("FAIL pending_hold: %0d bad cycles, final %b, want 1", bad, commit_pending); end
    n_checks++; if (dh_param !== '0) begin n_errors++; $display("FAIL no_early_swap: got %h, want 0", dh_param); end
    step();
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL pending_clear: got %b, want 0", commit_pending); end
    bad = 0;
    for (int j = 0; j < 6; j++)
      for (int p = 0; p < 4; p++)
        if (dh_param[j][p] !== vals[j*4 + p]) bad++;
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL swap_values: %0d words differ, want 0", bad); end
    for (int k = 0; k < NW; k++) begin
      bus_read(6'(32 + k), d);
      n_checks++;
      if (d !== sx(vals[k])) begin n_errors++; $display("FAIL active_read[%0d]: got %h, want %h", k, d, sx(vals[k])); end
    end
  endtask

  task automatic test_swap_edge();
    logic [31:0] d;
    logic [26:0] a;
    a = 27'($urandom) | 27'h100;
    bus_write(6'd0, {5'h0, a});
    bus_write(6'd24, 32'h1);
    wait_count(FRAME - 1);
    bus_write(6'd0, 32'h0000_0055);
    n_checks++; if (dh_param[0][0] !== a) begin n_errors++; $display("FAIL edge_write_active: got %h, want %h", dh_param[0][0], a); end
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL edge_write_pending: got %b, want 0", commit_pending); end
    bus_read(6'd0, d);
    n_checks++; if (d !== 32'h55) begin n_errors++; $display("FAIL edge_write_shadow: got %h, want 00000055", d); end
    bus_write(6'd24, 32'h1);
    wait_count(FRAME - 1);
    bus_write(6'd24, 32'h1);
    n_checks++; if (dh_param[0][0] !== 27'h55) begin n_errors++; $display("FAIL edge_commit_active: got %h, want 55", dh_param[0][0]); end
    n_checks++; if (commit_pending !== 1'b1) begin n_errors++; $display("FAIL edge_commit_pending: got %b, want 1", commit_pending); end
    wait_count(FRAME - 1);
    step();
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL second_swap_pending: got %b, want 0", commit_pending); end
    n_checks++; if (dh_param !== model_active()) begin n_errors++; $display("FAIL second_swap_bank: got %h, want %h", dh_param, model_active()); end
  endtask

  task automatic test_en_hold();
    logic [26:0] b;
    logic [26:0] old;
    int bad = 0;
    b = 27'($urandom);
    old = m_active[1];
    bus_write(6'd1, {5'h0, b});
    bus_write(6'd24, 32'h1);
    wait_count(FRAME - 2);
    en = 1'b0;
    repeat (10) begin
      step();
      if (frame_done !== 1'b0 || commit_pending !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL hold_before_end: %0d bad cycles, want 0", bad); end
    en = 1'b1;
    step();
    en = 1'b0;
    bad = 0;
    repeat (10) begin
      step();
      if (dh_param[0][1] !== old || commit_pending !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL hold_no_swap: %0d bad cycles, want 0", bad); end
    en = 1'b1;
    step();
    n_checks++; if (dh_param[0][1] !== b) begin n_errors++; $display("FAIL hold_resume_swap: got %h, want %h", dh_param[0][1], b); end
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL hold_resume_pending: got %b, want 0", commit_pending); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [26:0] c;
    c = 27'($urandom) | 27'h1;
    bus_write(6'd2, {5'h0, c});
    bus_write(6'd24, 32'h1);
    bus_read(6'd2, d);
    wait_count(50);
    rst = 1'b1;
    #2;
    n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("FAIL midrst_readdata: got %h, want 0", readdata); end
    n_checks++; if (dh_param !== '0) begin n_errors++; $display("FAIL midrst_dh_param: got %h, want 0", dh_param); end
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL midrst_pending: got %b, want 0", commit_pending); end
    n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL midrst_frame_done: got %b, want 0", frame_done); end
    @(negedge clk) rst = 1'b0;
    step();
    wait_count(FRAME - 1);
    step();
    n_checks++; if (dh_param !== '0 || commit_pending !== 1'b0) begin n_errors++; $display("FAIL midrst_commit_lost: bank %h pending %b, want 0 0", dh_param, commit_pending); end
  endtask

  task automatic test_autocommit();
    n_checks++; if (commit_pending !== 1'b0) begin n_errors++; $display("FAIL auto_pre: got %b, want 0", commit_pending); end
    bus_write(6'd23, $urandom);
    n_checks++; if (commit_pending !== AUTO) begin n_errors++; $display("FAIL auto_commit: got %b, want %b", commit_pending, AUTO); end
    wait_count(FRAME - 1);
    step();
  endtask

  task automatic test_random();
    int bad_rd = 0, bad_pend = 0, bad_fd = 0, bad_bank = 0;
    for (int i = 0; i < 600; i++) begin
      int op;
      en = ($urandom_range(0, 9) != 0);
      op = $urandom_range(0, 4);
      chipselect = (op != 0) && ($urandom_range(0, 7) != 0);
      write = (op == 2 || op == 3);
      read  = (op == 1 || op == 4);
      address = (op == 3) ? 6'd24 : 6'($urandom_range(0, 63));
      writedata = $urandom;
      step();
      n_checks++; if (readdata !== m_readdata) begin bad_rd++; n_errors++; $display("FAIL rand_readdata @%0d: got %h, want %h", i, readdata, m_readdata); end
      n_checks++; if (commit_pending !== m_pending) begin bad_pend++; n_errors++; $display("FAIL rand_pending @%0d: got %b, want %b", i, commit_pending, m_pending); end
      n_checks++; if (frame_done !== (m_count == FRAME - 1)) begin bad_fd++; n_errors++; $display("FAIL rand_frame_done @%0d: got %b, want %b", i, frame_done, (m_count == FRAME - 1)); end
      n_checks++; if (dh_param !== model_active()) begin bad_bank++; n_errors++; $display("FAIL rand_bank @%0d: got %h, want %h", i, dh_param, model_active()); end
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0; en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_shadow_rw();
    test_commit();
    test_swap_edge();
    test_en_hold();
    test_reset_mid();
    test_autocommit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
